// File: rtl/fifo_tx_pkg.sv
// Shared types and line levels for the FIFO-fed serial transmitter.
package fifo_tx_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: bit_end is a registered one-cycle pulse on the last
// clk cycle of every CLKS_PER_BIT-long bit period while run is held high.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    // bit_end is set one cycle ahead so that it lines up with count == LAST.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count   <= '0;
            bit_end <= 1'b0;
        end else begin
            count   <= (count == LAST) ? '0 : count + 1'b1;
            bit_end <= (count == PRE_LAST);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends each as start bit, LSB-first
// data bits and stop bit.
//
// Handshake with the FIFO: fifo_rd_en is a one-cycle strobe issued only from
// IDLE after fifo_empty was seen low; the FIFO presents fifo_data the next
// cycle (WAIT), where it is captured into the shift register.
module fifo_uart_tx
    import fifo_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output tx_state_t             dbg_state
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t             state;
    tx_state_t             next_state;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] next_shift;
    logic [BW-1:0]         bit_idx;
    logic [BW-1:0]         next_bit_idx;
    logic                  next_rd_en;
    logic                  next_tx;
    logic                  next_busy;
    logic                  run;
    logic                  bit_end;

    assign run       = (state == START) || (state == DATA) || (state == STOP);
    assign dbg_state = state;
    assign tx_done   = (state == STOP) && bit_end;

    tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bit_end (bit_end)
    );

    always_comb begin
        next_state   = state;
        next_shift   = shift;
        next_bit_idx = bit_idx;
        case (state)
            IDLE:  if (fifo_rd_en) next_state = WAIT;
            WAIT: begin
                next_shift   = fifo_data;
                next_bit_idx = '0;
                next_state   = START;
            end
            START: if (bit_end) next_state = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
                        next_state = STOP;
                    end else begin
                        next_bit_idx = bit_idx + 1'b1;
                        next_shift   = shift >> 1;
                    end
                end
            end
            STOP:  if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        next_rd_en = (next_state == IDLE) && !fifo_empty;
        next_busy  = (next_state != IDLE) || next_rd_en;
        case (next_state)
            START:   next_tx = START_LEVEL;
            DATA:    next_tx = next_shift[0];
            STOP:    next_tx = STOP_LEVEL;
            default: next_tx = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            fifo_rd_en <= 1'b0;
            tx         <= TX_IDLE_LEVEL;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            shift      <= next_shift;
            bit_idx    <= next_bit_idx;
            fifo_rd_en <= next_rd_en;
            tx         <= next_tx;
            busy       <= next_busy;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a queue-based FIFO model feeding it and a
// frame model that derives every expected line level from the byte value.
module tb_fifo_uart_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;
    fifo_tx_pkg::tx_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;
    int rd_violations = 0;
    int pushed = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] wr_pend_q[$];
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    // clock / reset
    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .dbg_state  (dbg_state)
    );

    // FIFO write port driver: one queued byte per cycle
    always @(negedge clk) begin
        if (wr_pend_q.size() > 0) begin
            wr_en   = 1'b1;
            wr_data = wr_pend_q.pop_front();
        end else begin
            wr_en = 1'b0;
        end
    end

    // synchronous FIFO model; data_out is valid the cycle after r_en
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pop_count++;
            if (mem_q.size() == 0) rd_violations++;
            else fifo_data <= mem_q.pop_front();
        end
        if (wr_en && mem_q.size() < DEPTH) mem_q.push_back(wr_data);
        fifo_empty <= (mem_q.size() == 0);
    end

    task automatic queue_byte(input logic [DW-1:0] b);
        wr_pend_q.push_back(b);
        exp_q.push_back(b);
        pushed++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        chk1({tag, "_tx"}, tx, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_tx_done"}, tx_done, 1'b0);
    endtask

    // Waits (bounded) for the pop strobe, then checks ncycles of the frame.
    task automatic check_frame(input int max_wait, input int ncycles);
        logic [DW-1:0] b;
        logic          exp_tx;
        bit            got;
        int            waited;
        int            bitpos;
        string         t;
        b = '0;
        got = 0;
        waited = 0;
        if (exp_q.size() > 0) b = exp_q.pop_front();
        t = $sformatf("frame_%02h", b);
        while (!got && waited < max_wait) begin
            @(negedge clk);
            waited++;
            if (fifo_rd_en === 1'b1) got = 1;
            else begin
                chk1({t, "_idle_tx"}, tx, 1'b1);
                chk1({t, "_idle_busy"}, busy, 1'b0);
            end
        end
        chk1({t, "_rd_en_pulse"}, got, 1'b1);
        if (got) begin
            @(negedge clk);
            chk1({t, "_wait_rd_en"}, fifo_rd_en, 1'b0);
            chk1({t, "_wait_tx"}, tx, 1'b1);
            chk1({t, "_wait_busy"}, busy, 1'b1);
            for (int i = 0; i < ncycles; i++) begin
                @(negedge clk);
                bitpos = i / CPB;
                if (bitpos == 0) exp_tx = 1'b0;
                else if (bitpos <= DW) exp_tx = b[bitpos-1];
                else exp_tx = 1'b1;
                chk1({t, "_tx"}, tx, exp_tx);
                chk1({t, "_busy"}, busy, 1'b1);
                chk1({t, "_tx_done"}, tx_done, i == FRAME - 1);
                chk1({t, "_rd_en"}, fifo_rd_en, 1'b0);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] rb;
        int            gap;

        // reset held while the FIFO already has data
        queue_byte(8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle("reset");
        end
        rst = 1'b0;

        // single byte, then line returns to idle
        check_frame(4, FRAME);
        @(negedge clk);
        chk_idle("after_a5");

        // back-to-back bytes: the next pop must come right after the stop bit
        queue_byte(8'h00);
        queue_byte(8'hFF);
        queue_byte(8'h3C);
        check_frame(8, FRAME);
        check_frame(1, FRAME);
        check_frame(1, FRAME);

        // empty FIFO
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk_idle("empty");
        end

        // reset in the middle of the data bits, then a clean next frame
        queue_byte(8'h55);
        queue_byte(8'h81);
        check_frame(8, CPB + 4 * CPB);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        rst = 1'b0;
        check_frame(4, FRAME);

        // random bytes with random idle gaps
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom_range(0, 255));
            queue_byte(rb);
            check_frame(8, FRAME);
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk_idle("rand_gap");
            end
        end

        // fill the FIFO with 0x10..0x17 and let the transmitter drain it
        for (int v = 16; v < 24; v++) queue_byte(8'(v));
        check_frame(8, FRAME);
        for (int k = 1; k < 8; k++) check_frame(1, FRAME);
        @(negedge clk);
        chk_idle("drained");

        // final report
        chk_n("pop_count", pop_count, pushed);
        chk_n("rd_while_empty", rd_violations, 0);
        chk_n("frames_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
